glyph_row_writer: RTL and testbench

//   Write side of the character-glyph store: takes a serial pixel-bit stream (left-to-right, top-to-bottom),

---
 rtl/glyph_row_writer_pkg.sv | 17 +
 rtl/glyph_row_writer_if.sv | 35 +++
 rtl/glyph_row_writer_packer.sv | 42 ++++
 rtl/glyph_row_writer.sv | 133 +++++++++++++
 tb/tb_glyph_row_writer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/glyph_row_writer_pkg.sv
// Shared glyph-store geometry and write-side FSM encodings.
// Defaults are common to the loader, the display reader and the glyph RAM.
package glyph_row_writer_pkg;

    localparam int DEF_ROW_W          = 16;
    localparam int DEF_ROWS_PER_GLYPH = 16;
    localparam int DEF_CHAR_W         = 7;
    localparam int DEF_ROW_AW         = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/glyph_row_writer_if.sv
// Pixel stream in (valid/ready) plus glyph RAM write port out.
// master: loader/RAM side. slave: glyph_row_writer.
interface glyph_row_writer_if
    import glyph_row_writer_pkg::*;
#(
    parameter int ROW_W = DEF_ROW_W,
    parameter int AW    = DEF_CHAR_W + DEF_ROW_AW
) ();

    logic             pix_valid;
    logic             pix_bit;
    logic             pix_ready;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [ROW_W-1:0] wr_data;

    modport master (
        output pix_valid,
        output pix_bit,
        input  pix_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  pix_valid,
        input  pix_bit,
        output pix_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/glyph_row_writer_packer.sv
// row_shift_packer: W-bit MSB-first shift register with bit counter.
// Ports: shift_en/bit_in shift one pixel, clear restarts the row,
// row_word = word including the bit being shifted now,
// row_full = this shift completes the row.
module row_shift_packer
    import glyph_row_writer_pkg::*;
#(
    parameter int W = DEF_ROW_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         clear,
    input  logic         bit_in,
    output logic [W-1:0] row_word,
    output logic         row_full
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  shreg;
    logic [CW-1:0] bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= {shreg[W-2:0], bit_in};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Look-ahead word lets the top capture the row on the same edge
    // that accepts its last pixel.
    assign row_word = {shreg[W-2:0], bit_in};
    assign row_full = shift_en && (bit_cnt == CW'(W - 1));

endmodule

// File: rtl/glyph_row_writer.sv
// glyph_row_writer: packs a serial pixel stream into glyph rows and
// writes them to the glyph RAM at {char_code, row}.
// Ports: clk, rst_n (async low); start/start_char/num_chars begin a load;
// abort cancels; busy/done report status; bus = pixel in + RAM write out.
module glyph_row_writer
    import glyph_row_writer_pkg::*;
#(
    parameter int ROW_W          = DEF_ROW_W,
    parameter int ROWS_PER_GLYPH = DEF_ROWS_PER_GLYPH,
    parameter int CHAR_W         = DEF_CHAR_W,
    parameter int ROW_AW         = DEF_ROW_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAR_W-1:0] start_char,
    input  logic [CHAR_W:0]   num_chars,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    glyph_row_writer_if.slave bus
);

    state_t state;
    state_t state_nx;

    logic [ROW_AW-1:0]        row;
    logic [CHAR_W-1:0]        char_ptr;
    logic [CHAR_W:0]          remaining;
    logic [CHAR_W+ROW_AW-1:0] wr_addr_q;
    logic [ROW_W-1:0]         wr_data_q;

    logic             hs;
    logic             clear;
    logic             row_full;
    logic             last_row;
    logic             accept;
    logic [ROW_W-1:0] row_word;

    assign hs       = bus.pix_valid && (state == ST_LOAD);
    assign clear    = (state != ST_LOAD);
    assign last_row = (row == ROW_AW'(ROWS_PER_GLYPH - 1));
    assign accept   = (state == ST_IDLE) && start && !abort;

    row_shift_packer #(
        .W (ROW_W)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (hs),
        .clear    (clear),
        .bit_in   (bus.pix_bit),
        .row_word (row_word),
        .row_full (row_full)
    );

    always_comb begin
        state_nx      = state;
        bus.pix_ready = 1'b0;
        bus.wr_en     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = (num_chars != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                bus.pix_ready = 1'b1;
                busy          = 1'b1;
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (row_full) begin
                    state_nx = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus.wr_en = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (last_row && remaining == (CHAR_W+1)'(1)) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_LOAD;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            row       <= '0;
            char_ptr  <= '0;
            remaining <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state <= state_nx;
            if (accept && num_chars != '0) begin
                char_ptr  <= start_char;
                remaining <= num_chars;
                row       <= '0;
            end
            if (state == ST_WRITE && !abort) begin
                if (!last_row) begin
                    row <= row + 1'b1;
                end else begin
                    row       <= '0;
                    char_ptr  <= char_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
            end
            // Port registers load only when a write will follow, so
            // they hold the last written row otherwise.
            if (state == ST_LOAD && state_nx == ST_WRITE) begin
                wr_addr_q <= {char_ptr, row};
                wr_data_q <= row_word;
            end
        end
    end

    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_glyph_row_writer.sv
// Directed bench for glyph_row_writer with a write scoreboard.
module tb_glyph_row_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] start_char;
    logic [7:0] num_chars;
    logic       abort;
    logic       busy;
    logic       done;

    glyph_row_writer_if #(.ROW_W(16), .AW(11)) bus ();

    glyph_row_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_char (start_char),
        .num_chars  (num_chars),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [26:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            logic [26:0] e;
            wr_cnt++;
            chk("pix_ready_in_write", bus.pix_ready, 0);
            chk("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.wr_addr, e[26:16]);
                chk("wr_data", bus.wr_data, e[15:0]);
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [15:0] pat(input int kind, input logic [6:0] c,
                                        input int r);
        if (kind == 0) return 16'h8001;
        if (kind == 1) return (r % 2 == 0) ? 16'h8000 : 16'h0001;
        return 16'h1234 + 16'(r) * 16'h1111 + {9'h0, c};
    endfunction

    task automatic do_start(input logic [6:0] c, input logic [7:0] n);
        start = 1'b1;
        start_char = c;
        num_chars = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n,
                             input bit tog);
        for (int i = 0; i < n; i++) begin
            int budget;
            if (tog) begin
                bus.pix_valid = 1'b0;
                @(negedge clk);
            end
            bus.pix_valid = 1'b1;
            bus.pix_bit = w[15-i];
            budget = 0;
            while (bus.pix_ready !== 1'b1 && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            chk("ready_within_budget", budget < 50, 1);
            @(negedge clk);
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic send_rows(input logic [6:0] c, input int kind,
                             input int r0, input int r1, input bit tog);
        for (int r = r0; r <= r1; r++) begin
            exp_q.push_back({c, 4'(r), pat(kind, c, r)});
            send_bits(pat(kind, c, r), 16, tog);
        end
    endtask

    task automatic end_check(input string tag, input int w0, input int nw);
        @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_low"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_writes"}, wr_cnt - w0, nw);
    endtask

    initial begin
        int w0;
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        start_char = '0;
        num_chars = '0;
        abort = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_bit = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_pix_ready", bus.pix_ready, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        w0 = wr_cnt;
        do_start(7'h41, 8'd1);
        chk("c1_busy", busy, 1);
        chk("c1_pix_ready", bus.pix_ready, 1);
        send_rows(7'h41, 0, 0, 15, 1'b0);
        end_check("c1", w0, 16);

        w0 = wr_cnt;
        do_start(7'h10, 8'd1);
        send_rows(7'h10, 1, 0, 15, 1'b0);
        end_check("c2", w0, 16);

        w0 = wr_cnt;
        do_start(7'h41, 8'd1);
        send_rows(7'h41, 0, 0, 15, 1'b1);
        end_check("c3", w0, 16);

        w0 = wr_cnt;
        do_start(7'h7F, 8'd2);
        send_rows(7'h7F, 2, 0, 15, 1'b0);
        send_rows(7'h00, 2, 0, 15, 1'b0);
        end_check("c4", w0, 32);

        w0 = wr_cnt;
        do_start(7'h22, 8'd0);
        chk("c5_zero_done", done, 1);
        chk("c5_zero_busy", busy, 0);
        @(negedge clk);
        chk("c5_zero_done_pulse", done, 0);
        chk("c5_zero_writes", wr_cnt - w0, 0);

        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(7'h20, 8'd1);
        exp_q.push_back({7'h20, 4'd0, pat(2, 7'h20, 0)});
        send_bits(pat(2, 7'h20, 0), 5, 1'b0);
        do_start(7'h55, 8'd3);
        send_bits(pat(2, 7'h20, 0) << 5, 11, 1'b0);
        send_rows(7'h20, 2, 1, 15, 1'b0);
        end_check("c5_busy_start", w0, 16);
        chk("c5_done_count", done_cnt - d0, 1);

        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(7'h30, 8'd1);
        send_rows(7'h30, 2, 0, 2, 1'b0);
        send_bits(pat(2, 7'h30, 3), 5, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("c6_abort_busy", busy, 0);
        chk("c6_abort_ready", bus.pix_ready, 0);
        chk("c6_hold_addr", bus.wr_addr, {7'h30, 4'd2});
        chk("c6_hold_data", bus.wr_data, pat(2, 7'h30, 2));
        repeat (40) @(negedge clk);
        chk("c6_abort_writes", wr_cnt - w0, 3);
        chk("c6_abort_no_done", done_cnt - d0, 0);

        start = 1'b1;
        abort = 1'b1;
        start_char = 7'h01;
        num_chars = 8'd1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("c6_start_abort_busy", busy, 0);
        chk("c6_start_abort_done", done, 0);

        do_start(7'h31, 8'd1);
        send_bits(16'hFFFF, 7, 1'b0);
        chk("c6_pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("c6_rst_busy", busy, 0);
        chk("c6_rst_ready", bus.pix_ready, 0);
        chk("c6_rst_wr_en", bus.wr_en, 0);
        chk("c6_rst_done", done, 0);
        chk("c6_rst_wr_addr", bus.wr_addr, 0);
        chk("c6_rst_wr_data", bus.wr_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("c6_after_rst_busy", busy, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
